// File: rtl/fwd_scoreboard_if.sv
// Handshake bundle between the ID stage and the forwarding/hazard scoreboard.
// The master drives ID contents and pipeline control; the slave returns stall and select info.
interface fwd_scoreboard_if #(
  parameter int REG_W   = 3,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
);
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_en;
  logic [REG_W-1:0]         id_dest;
  logic                     id_reg_write;
  logic                     id_is_load;
  logic                     pipe_stall;
  logic                     flush;
  logic                     hazard_stall;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output id_valid, id_src, id_src_en, id_dest, id_reg_write, id_is_load, pipe_stall, flush,
    input  hazard_stall, ex_fwd_sel, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_en, id_dest, id_reg_write, id_is_load, pipe_stall, flush,
    output hazard_stall, ex_fwd_sel, stall_count
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight writers from EX to WB, registers per-operand
// forwarding selects for the instruction entering EX, and requests load-use bubbles.
module fwd_scoreboard #(
  parameter int REG_W     = 3,
  parameter int NUM_SRC   = 3,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_scoreboard_if.slave   bus
);

  logic [FWD_DEPTH-1:0]     slot_v;
  logic [FWD_DEPTH-1:0]     slot_load;
  logic [REG_W-1:0]         slot_dest [FWD_DEPTH];
  logic [NUM_SRC*SEL_W-1:0] sel_reg;
  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic [CNT_W-1:0]         cnt;
  logic                     load_use;
  logic                     found;
  int                       kstar;
  logic                     hazard;
  logic                     issue;

  // Scan oldest to youngest so the youngest matching writer is the one left in kstar.
  always_comb begin
    sel_next = '0;
    load_use = 1'b0;
    found    = 1'b0;
    kstar    = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      found = 1'b0;
      kstar = 0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (slot_v[k] && (slot_dest[k] == bus.id_src[j*REG_W +: REG_W]) &&
            bus.id_src_en[j] && bus.id_valid) begin
          found = 1'b1;
          kstar = k;
        end
      end
      if (found) begin
        sel_next[j*SEL_W +: SEL_W] = SEL_W'(kstar + 1);
        if ((kstar < LOAD_LAT) && slot_load[kstar]) begin
          load_use = 1'b1;
        end
      end
    end
  end

  assign hazard = load_use & ~bus.flush;
  assign issue  = bus.id_valid & ~bus.flush & ~hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_v    <= '0;
      slot_load <= '0;
      sel_reg   <= '0;
      cnt       <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        slot_dest[k] <= '0;
      end
    end else if (!bus.pipe_stall) begin
      for (int k = FWD_DEPTH - 1; k > 0; k--) begin
        slot_v[k]    <= slot_v[k-1];
        slot_load[k] <= slot_load[k-1];
        slot_dest[k] <= slot_dest[k-1];
      end
      slot_v[0]    <= issue & bus.id_reg_write;
      slot_load[0] <= issue & bus.id_is_load;
      slot_dest[0] <= bus.id_dest;
      sel_reg      <= issue ? sel_next : '0;
      if (hazard && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.hazard_stall = hazard;
  assign bus.ex_fwd_sel   = sel_reg;
  assign bus.stall_count  = cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed pipeline scenarios plus randomized
// traffic compared against an instruction-history reference model.
module tb_fwd_scoreboard;
  localparam int FWD_DEPTH = 2;
  localparam int LOAD_LAT  = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fwd_scoreboard_if #(.REG_W(3), .NUM_SRC(3), .SEL_W(2), .CNT_W(16)) bus ();
  fwd_scoreboard_if #(.REG_W(3), .NUM_SRC(3), .SEL_W(2), .CNT_W(5))  bus_s ();

  fwd_scoreboard dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fwd_scoreboard #(.CNT_W(5)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  assign bus_s.id_valid     = bus.id_valid;
  assign bus_s.id_src       = bus.id_src;
  assign bus_s.id_src_en    = bus.id_src_en;
  assign bus_s.id_dest      = bus.id_dest;
  assign bus_s.id_reg_write = bus.id_reg_write;
  assign bus_s.id_is_load   = bus.id_is_load;
  assign bus_s.pipe_stall   = bus.pipe_stall;
  assign bus_s.flush        = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of what entered EX on each advance, index 0 = most recent.
  typedef struct {bit v; int dest; bit load;} ent_t;
  ent_t       hist[$];
  int         m_cnt;
  logic [5:0] m_sel;
  bit         obs_hz, obs_hz_s, exp_hz;

  task automatic model_clear();
    ent_t e;
    e.v = 0; e.dest = 0; e.load = 0;
    hist = {};
    for (int i = 0; i < FWD_DEPTH; i++) hist.push_back(e);
    m_sel = '0;
    m_cnt = 0;
  endtask

  task automatic model_eval(output bit hz, output logic [5:0] sel);
    hz  = 0;
    sel = '0;
    for (int j = 0; j < 3; j++) begin
      int src;
      src = int'(bus.id_src[3*j +: 3]);
      if (!bus.id_valid || !bus.id_src_en[j]) continue;
      for (int a = 0; a < hist.size(); a++) begin
        if (hist[a].v && hist[a].dest == src) begin
          sel[j*2 +: 2] = 2'(a + 1);
          if (a < LOAD_LAT && hist[a].load) hz = 1;
          break;
        end
      end
    end
    if (bus.flush) hz = 0;
  endtask

  task automatic cycle(input bit v, input logic [2:0] s0, s1, s2, input logic [2:0] en,
                       input logic [2:0] d, input bit rw, ld, ps, fl);
    bit         hz;
    bit         iss;
    logic [5:0] nsel;
    ent_t       e;
    bus.id_valid     = v;
    bus.id_src       = {s2, s1, s0};
    bus.id_src_en    = en;
    bus.id_dest      = d;
    bus.id_reg_write = rw;
    bus.id_is_load   = ld;
    bus.pipe_stall   = ps;
    bus.flush        = fl;
    #1;
    obs_hz   = bus.hazard_stall;
    obs_hz_s = bus_s.hazard_stall;
    model_eval(hz, nsel);
    exp_hz = hz;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (!ps) begin
      iss    = v && !fl && !hz;
      e.v    = iss && rw;
      e.dest = int'(d);
      e.load = iss && ld;
      hist.push_front(e);
      void'(hist.pop_back());
      m_sel = iss ? nsel : 6'b0;
      if (hz) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1, 1, 2, 3, 3'b111, 1, 1, 1, 0, 0);
    cycle(1, 1, 2, 3, 3'b111, 1, 1, 1, 0, 0);
    checks++; if (bus.ex_fwd_sel !== 6'b0) begin errors++; $display("FAIL reset_sel got %0h want 0", bus.ex_fwd_sel); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.stall_count); end
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL reset_hz got %0b want 0", obs_hz); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_fwd();
    do_reset();
    cycle(1, 5, 6, 0, 3'b011, 1, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL alu_hz1 got %0b want 0", obs_hz); end
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL alu_hz2 got %0b want 0", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b000001) begin errors++; $display("FAIL alu_sel got %0h want 01", bus.ex_fwd_sel); end
  endtask

  task automatic test_gap();
    do_reset();
    cycle(1, 5, 6, 0, 3'b011, 1, 1, 0, 0, 0);
    idle();
    cycle(1, 1, 3, 0, 3'b011, 4, 1, 0, 0, 0);
    checks++; if (bus.ex_fwd_sel !== 6'b000010) begin errors++; $display("FAIL gap1_sel got %0h want 02", bus.ex_fwd_sel); end
    do_reset();
    cycle(1, 5, 6, 0, 3'b011, 1, 1, 0, 0, 0);
    idle(); idle(); idle();
    cycle(1, 1, 3, 0, 3'b011, 4, 1, 0, 0, 0);
    checks++; if (bus.ex_fwd_sel !== 6'b000000) begin errors++; $display("FAIL gap3_sel got %0h want 00", bus.ex_fwd_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    cycle(1, 6, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL lu_ldr_hz got %0b want 0", obs_hz); end
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL lu_hz got %0b want 1", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b0) begin errors++; $display("FAIL lu_bubble_sel got %0h want 00", bus.ex_fwd_sel); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", bus.stall_count); end
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL lu_hz_clear got %0b want 0", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b000010) begin errors++; $display("FAIL lu_sel got %0h want 02", bus.ex_fwd_sel); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_cnt2 got %0d want 1", bus.stall_count); end
  endtask

  task automatic test_shadow();
    do_reset();
    cycle(1, 6, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    cycle(1, 2, 3, 0, 3'b011, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 3'b011, 5, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL shadow_hz got %0b want 0", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b000001) begin errors++; $display("FAIL shadow_sel got %0h want 01", bus.ex_fwd_sel); end
    cycle(1, 1, 0, 5, 3'b011, 0, 0, 0, 0, 0);
    checks++; if (bus.ex_fwd_sel !== 6'b000010) begin errors++; $display("FAIL store_sel got %0h want 02", bus.ex_fwd_sel); end
  endtask

  task automatic test_pipe_stall_flush();
    do_reset();
    cycle(1, 4, 0, 0, 3'b001, 6, 1, 0, 0, 0);
    cycle(1, 6, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 1, 0);
      checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL ps_hz[%0d] got %0b want 1", i, obs_hz); end
      checks++; if (bus.ex_fwd_sel !== 6'b000001) begin errors++; $display("FAIL ps_sel[%0d] got %0h want 01", i, bus.ex_fwd_sel); end
      checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL ps_cnt[%0d] got %0d want 0", i, bus.stall_count); end
    end
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b1) begin errors++; $display("FAIL rel_hz got %0b want 1", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b0) begin errors++; $display("FAIL rel_sel got %0h want 00", bus.ex_fwd_sel); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL rel_cnt got %0d want 1", bus.stall_count); end
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    checks++; if (bus.ex_fwd_sel !== 6'b000010) begin errors++; $display("FAIL rel_sel2 got %0h want 02", bus.ex_fwd_sel); end
    cycle(1, 7, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 1);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL flush_hz got %0b want 0", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b0) begin errors++; $display("FAIL flush_sel got %0h want 00", bus.ex_fwd_sel); end
    cycle(1, 1, 0, 0, 3'b001, 3, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL flush_next_hz got %0b want 0", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b000010) begin errors++; $display("FAIL flush_next_sel got %0h want 02", bus.ex_fwd_sel); end
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", bus.stall_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 6, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL rm_pre_cnt got %0d want 1", bus.stall_count); end
    rst_n = 1'b0;
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    rst_n = 1'b1;
    checks++; if (bus.ex_fwd_sel !== 6'b0) begin errors++; $display("FAIL rm_sel got %0h want 00", bus.ex_fwd_sel); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL rm_cnt got %0d want 0", bus.stall_count); end
    cycle(1, 1, 3, 0, 3'b011, 2, 1, 0, 0, 0);
    checks++; if (obs_hz !== 1'b0) begin errors++; $display("FAIL rm_hz got %0b want 0", obs_hz); end
    checks++; if (bus.ex_fwd_sel !== 6'b0) begin errors++; $display("FAIL rm_sel2 got %0h want 00", bus.ex_fwd_sel); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 200; i++) cycle(1, 1, 0, 0, 3'b001, 1, 1, 1, 0, 0);
    checks++; if (bus.stall_count !== 16'd100) begin errors++; $display("FAIL sat_cnt16 got %0d want 100", bus.stall_count); end
    checks++; if (bus_s.stall_count !== 5'd31) begin errors++; $display("FAIL sat_cnt5 got %0d want 31", bus_s.stall_count); end
  endtask

  task automatic test_random();
    int exp16, exp5;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      cycle($urandom_range(0, 9) != 0,
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom), 3'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      rst_n = 1'b1;
      exp16 = (m_cnt > 65535) ? 65535 : m_cnt;
      exp5  = (m_cnt > 31) ? 31 : m_cnt;
      checks++; if (obs_hz !== exp_hz) begin errors++; $display("FAIL rnd_hz[%0d] got %0b want %0b", i, obs_hz, exp_hz); end
      checks++; if (obs_hz_s !== exp_hz) begin errors++; $display("FAIL rnd_hz_s[%0d] got %0b want %0b", i, obs_hz_s, exp_hz); end
      checks++; if (bus.ex_fwd_sel !== m_sel) begin errors++; $display("FAIL rnd_sel[%0d] got %0h want %0h", i, bus.ex_fwd_sel, m_sel); end
      checks++; if (bus_s.ex_fwd_sel !== m_sel) begin errors++; $display("FAIL rnd_sel_s[%0d] got %0h want %0h", i, bus_s.ex_fwd_sel, m_sel); end
      checks++; if (bus.stall_count !== 16'(exp16)) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, bus.stall_count, exp16); end
      checks++; if (bus_s.stall_count !== 5'(exp5)) begin errors++; $display("FAIL rnd_cnt5[%0d] got %0d want %0d", i, bus_s.stall_count, exp5); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    model_clear();
    bus.id_valid = 0; bus.id_src = '0; bus.id_src_en = '0; bus.id_dest = '0;
    bus.id_reg_write = 0; bus.id_is_load = 0; bus.pipe_stall = 0; bus.flush = 0;
    @(negedge clk);
    test_reset();
    test_alu_fwd();
    test_gap();
    test_load_use();
    test_shadow();
    test_pipe_stall_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
